// File: rtl/sort_frame_scheduler_pkg.sv
// Shared types and helpers for the sort frame scheduler: state encoding and counter sizing.
`default_nettype none

package sort_sched_pkg;

  typedef enum logic [2:0] {
    FILL   = 3'd0,
    CLEAR  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    DRAIN  = 3'd4
  } sched_state_t;

  // Width of a counter addressing n entries; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sort_frame_scheduler.sv
// ============================================================================
// Module      : sort_frame_scheduler
// Description : Collects a frame of SIZE samples, runs the external bitonic
//               sorter on it and streams the ranked samples with their arrival
//               indices. Optional sorter watchdog: define SORT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sort_frame_scheduler
  import sort_sched_pkg::*;
#(
  parameter int SIZE           = 4,
  parameter int NETWORK_WIDTH  = 8,
  parameter int INDEX_WIDTH    = cnt_width(SIZE),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NETWORK_WIDTH-1:0]      in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NETWORK_WIDTH-1:0]      out_data,
  output logic [INDEX_WIDTH-1:0]        out_index,
  output logic                          out_last,
  output logic                          sorter_reset,
  output logic                          sorter_ready,
  output logic [SIZE*NETWORK_WIDTH-1:0] sorter_data_in,
  output logic [SIZE*INDEX_WIDTH-1:0]   sorter_index_in,
  input  logic [SIZE*NETWORK_WIDTH-1:0] sorter_data_out,
  input  logic [SIZE*INDEX_WIDTH-1:0]   sorter_index_out,
  input  logic                          sorter_done,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int                 C_CNT_W = cnt_width(SIZE);
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(SIZE - 1);

  if ((SIZE < 2) || ((SIZE & (SIZE - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("sort_frame_scheduler: SIZE must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  sched_state_t             r_state;
  logic [C_CNT_W-1:0]       r_fill_cnt;
  logic [C_CNT_W-1:0]       r_ptr;
  logic [NETWORK_WIDTH-1:0] r_frame    [SIZE];
  logic [INDEX_WIDTH-1:0]   r_idx      [SIZE];
  logic [NETWORK_WIDTH-1:0] r_res_data [SIZE];
  logic [INDEX_WIDTH-1:0]   r_res_idx  [SIZE];
  logic                     r_sorter_reset;
  logic                     r_sorter_ready;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic [NETWORK_WIDTH-1:0] r_out_data;
  logic [INDEX_WIDTH-1:0]   r_out_index;
  logic                     r_busy;
  logic [C_CNT_W-1:0]       w_ptr_next;

`ifdef SORT_TIMEOUT_EN
  localparam int                  C_WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [C_WAIT_W-1:0] r_wait_cnt;
  logic                r_abort;
  logic                r_timeout_err;

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign w_ptr_next = r_ptr + C_CNT_W'(1);

  // The only combinational output; gated by reset so nothing is accepted while held.
  assign in_ready     = reset && (r_state == FILL);
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_index    = r_out_index;
  assign out_last     = r_out_last;
  assign sorter_reset = r_sorter_reset;
  assign sorter_ready = r_sorter_ready;
  assign busy         = r_busy;

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    assign sorter_data_in[g*NETWORK_WIDTH +: NETWORK_WIDTH] = r_frame[g];
    assign sorter_index_in[g*INDEX_WIDTH +: INDEX_WIDTH]    = r_idx[g];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= FILL;
      r_fill_cnt     <= '0;
      r_ptr          <= '0;
      r_sorter_reset <= 1'b1;
      r_sorter_ready <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_out_data     <= '0;
      r_out_index    <= '0;
      r_busy         <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        r_frame[i]    <= '0;
        r_idx[i]      <= '0;
        r_res_data[i] <= '0;
        r_res_idx[i]  <= '0;
      end
`ifdef SORT_TIMEOUT_EN
      r_wait_cnt     <= '0;
      r_abort        <= 1'b0;
      r_timeout_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        FILL: begin
          r_sorter_reset <= 1'b0;
          r_busy         <= 1'b0;
          if (in_valid) begin
            r_frame[r_fill_cnt] <= in_data;
            r_idx[r_fill_cnt]   <= INDEX_WIDTH'(r_fill_cnt);
            if (r_fill_cnt == C_LAST) begin
              r_fill_cnt     <= '0;
              r_state        <= CLEAR;
              r_sorter_reset <= 1'b1;
              r_busy         <= 1'b1;
            end else begin
              r_fill_cnt <= r_fill_cnt + C_CNT_W'(1);
            end
          end
        end

        CLEAR: begin
          r_sorter_reset <= 1'b0;
`ifdef SORT_TIMEOUT_EN
          if (r_abort) begin
            r_abort <= 1'b0;
            r_state <= FILL;
            r_busy  <= 1'b0;
          end else begin
            r_state        <= LAUNCH;
            r_sorter_ready <= 1'b1;
          end
`else
          r_state        <= LAUNCH;
          r_sorter_ready <= 1'b1;
`endif
        end

        LAUNCH: begin
          r_sorter_ready <= 1'b0;
          r_state        <= WAIT;
`ifdef SORT_TIMEOUT_EN
          r_wait_cnt     <= '0;
`endif
        end

        WAIT: begin
          if (sorter_done) begin
            for (int i = 0; i < SIZE; i++) begin
              r_res_data[i] <= sorter_data_out[i*NETWORK_WIDTH +: NETWORK_WIDTH];
              r_res_idx[i]  <= sorter_index_out[i*INDEX_WIDTH +: INDEX_WIDTH];
            end
            r_out_data  <= sorter_data_out[NETWORK_WIDTH-1:0];
            r_out_index <= sorter_index_out[INDEX_WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_ptr       <= '0;
            r_state     <= DRAIN;
          end
`ifdef SORT_TIMEOUT_EN
          // Stalled sorter: drop the frame and recycle it through CLEAR back to FILL.
          else if (r_wait_cnt == C_WAIT_LAST) begin
            r_timeout_err  <= 1'b1;
            r_abort        <= 1'b1;
            r_sorter_reset <= 1'b1;
            r_state        <= CLEAR;
          end else begin
            r_wait_cnt <= r_wait_cnt + C_WAIT_W'(1);
          end
`endif
        end

        DRAIN: begin
          if (out_ready) begin
            if (r_ptr == C_LAST) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_ptr       <= '0;
              r_busy      <= 1'b0;
              r_state     <= FILL;
            end else begin
              r_ptr       <= w_ptr_next;
              r_out_data  <= r_res_data[w_ptr_next];
              r_out_index <= r_res_idx[w_ptr_next];
              r_out_last  <= (w_ptr_next == C_LAST);
            end
          end
        end

        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sort_frame_scheduler.sv
// Self-checking bench for sort_frame_scheduler with a behavioural ascending sorter model.
`default_nettype none

module tb_sort_frame_scheduler;

  localparam int SIZE = 4;
  localparam int NW   = 8;
  localparam int IW   = 2;
  localparam int TO   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [NW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NW-1:0]     out_data;
  logic [IW-1:0]     out_index;
  logic              out_last;
  logic              sorter_reset;
  logic              sorter_ready;
  logic [SIZE*NW-1:0] sorter_data_in;
  logic [SIZE*IW-1:0] sorter_index_in;
  logic [SIZE*NW-1:0] sorter_data_out = '0;
  logic [SIZE*IW-1:0] sorter_index_out = '0;
  logic              sorter_done;
  logic              busy;
  logic              timeout_err;

  int total = 0;
  int bad   = 0;
  int rst_pulses = 0;
  logic prev_sr = 1'b0;

  sort_frame_scheduler #(
    .SIZE(SIZE), .NETWORK_WIDTH(NW), .INDEX_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last),
    .sorter_reset(sorter_reset), .sorter_ready(sorter_ready),
    .sorter_data_in(sorter_data_in), .sorter_index_in(sorter_index_in),
    .sorter_data_out(sorter_data_out), .sorter_index_out(sorter_index_out),
    .sorter_done(sorter_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Sorter model: ascending by value, ties by index, result appears only when done.
  logic                     hold_done = 1'b0;
  logic                     s_run  = 1'b0;
  logic                     s_done = 1'b0;
  int                       s_cnt  = 0;
  logic [SIZE*(NW+IW)-1:0]  s_pend = '0;

  function automatic logic [SIZE*(NW+IW)-1:0] sort_pack(input logic [SIZE*NW-1:0] d,
                                                         input logic [SIZE*IW-1:0] ix);
    int v[SIZE];
    int k[SIZE];
    int t;
    logic [SIZE*NW-1:0] od;
    logic [SIZE*IW-1:0] oi;
    for (int i = 0; i < SIZE; i++) begin
      v[i] = int'(d[i*NW +: NW]);
      k[i] = int'(ix[i*IW +: IW]);
    end
    for (int a = 0; a < SIZE - 1; a++)
      for (int b = 0; b < SIZE - 1 - a; b++)
        if (v[b] > v[b+1] || (v[b] == v[b+1] && k[b] > k[b+1])) begin
          t = v[b]; v[b] = v[b+1]; v[b+1] = t;
          t = k[b]; k[b] = k[b+1]; k[b+1] = t;
        end
    for (int i = 0; i < SIZE; i++) begin
      od[i*NW +: NW] = NW'(v[i]);
      oi[i*IW +: IW] = IW'(k[i]);
    end
    return {oi, od};
  endfunction

  assign sorter_done = s_done;

  always @(posedge clk) begin
    if (sorter_reset) begin
      s_run  <= 1'b0;
      s_done <= 1'b0;
    end else if (sorter_ready && !s_run) begin
      s_run           <= 1'b1;
      s_cnt           <= int'($urandom_range(1, 6));
      s_pend          <= sort_pack(sorter_data_in, sorter_index_in);
      sorter_data_out <= SIZE*NW'($urandom);
    end else if (s_run && !s_done && !hold_done) begin
      if (s_cnt == 0) begin
        s_done <= 1'b1;
        {sorter_index_out, sorter_data_out} <= s_pend;
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (sorter_reset && !prev_sr) rst_pulses++;
    prev_sr <= sorter_reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output order: repeatedly pick the smallest remaining sample, earliest arrival first.
  function automatic void ref_order(input int vals[SIZE], output int ed[SIZE], output int ei[SIZE]);
    bit used[SIZE];
    int best;
    for (int j = 0; j < SIZE; j++) used[j] = 1'b0;
    for (int r = 0; r < SIZE; r++) begin
      best = -1;
      for (int j = 0; j < SIZE; j++)
        if (!used[j] && (best < 0 || vals[j] < vals[best])) best = j;
      ed[r] = vals[best];
      ei[r] = best;
      used[best] = 1'b1;
    end
  endfunction

  task automatic send_frame(input int vals[SIZE], input int nbeats);
    logic [SIZE*NW-1:0] exp_d;
    logic [SIZE*IW-1:0] exp_i;
    bit acc;
    int guard;
    for (int i = 0; i < nbeats; i++) begin
      in_valid = 1'b1;
      in_data  = NW'(vals[i]);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        acc = in_ready;
        tick();
        guard++;
      end
      if (!acc) begin
        total++; bad++;
        $display("FAIL input_accept: beat %0d not accepted within %0d cycles", i, guard);
      end
    end
    in_valid = 1'b0;
    in_data  = NW'($urandom);
    if (nbeats == SIZE) begin
      for (int i = 0; i < SIZE; i++) begin
        exp_d[i*NW +: NW] = NW'(vals[i]);
        exp_i[i*IW +: IW] = IW'(i);
      end
      total++;
      if ({sorter_ready, sorter_reset, in_ready, busy} !== 4'b0101) begin
        bad++;
        $display("FAIL clear_phase: got rdy=%b rst=%b in_ready=%b busy=%b want 0 1 0 1",
                 sorter_ready, sorter_reset, in_ready, busy);
      end
      total++;
      if (sorter_data_in !== exp_d || sorter_index_in !== exp_i) begin
        bad++;
        $display("FAIL frame_lanes: got data=%h idx=%h want data=%h idx=%h",
                 sorter_data_in, sorter_index_in, exp_d, exp_i);
      end
      tick();
      total++;
      if (sorter_ready !== 1'b1 || sorter_reset !== 1'b0) begin
        bad++;
        $display("FAIL launch_latency: got sorter_ready=%b sorter_reset=%b want 1 0",
                 sorter_ready, sorter_reset);
      end
      tick();
      total++;
      if (sorter_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL launch_pulse: got sorter_ready=%b busy=%b want 0 1", sorter_ready, busy);
      end
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: five-cycle stall after the first entry
  task automatic drain_frame(input int vals[SIZE], input int mode);
    int ed[SIZE];
    int ei[SIZE];
    int k = 0;
    int guard = 0;
    int stall_left = 5;
    bit rdy;
    bit stalled = 1'b0;
    logic [NW-1:0] p_d;
    logic [IW-1:0] p_i;
    logic          p_l;
    ref_order(vals, ed, ei);
    while (k < SIZE && guard < 500) begin
      guard++;
      if (out_valid) begin
        if (stalled) begin
          total++;
          if ({out_data, out_index, out_last} !== {p_d, p_i, p_l}) begin
            bad++;
            $display("FAIL hold_stable: got %0d/%0d/%b want %0d/%0d/%b",
                     out_data, out_index, out_last, p_d, p_i, p_l);
          end
        end
        total++;
        if (out_data !== NW'(ed[k]) || out_index !== IW'(ei[k]) || out_last !== (k == SIZE - 1)) begin
          bad++;
          $display("FAIL out_entry%0d: got data=%0d idx=%0d last=%b want data=%0d idx=%0d last=%b",
                   k, out_data, out_index, out_last, ed[k], ei[k], (k == SIZE - 1));
        end
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) rdy = 1'($urandom_range(0, 1));
        else if (k == 1 && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else rdy = 1'b1;
        out_ready = rdy;
        stalled = !rdy;
        p_d = out_data; p_i = out_index; p_l = out_last;
        tick();
        if (rdy) k++;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    out_ready = 1'b0;
    if (k < SIZE) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d entries want %0d", k, SIZE);
    end
    total++;
    if ({out_valid, out_last, in_ready, busy} !== 4'b0010) begin
      bad++;
      $display("FAIL drain_end: got valid=%b last=%b in_ready=%b busy=%b want 0 0 1 0",
               out_valid, out_last, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    total++;
    if ({in_ready, sorter_reset, sorter_ready, out_valid, out_last, busy, timeout_err} !== 7'b0100000) begin
      bad++;
      $display("FAIL reset_outputs: got in_ready=%b srst=%b srdy=%b ov=%b ol=%b busy=%b to=%b want 0 1 0 0 0 0 0",
               in_ready, sorter_reset, sorter_ready, out_valid, out_last, busy, timeout_err);
    end
    total++;
    if (sorter_data_in !== '0 || sorter_index_in !== '0) begin
      bad++;
      $display("FAIL reset_buffers: got data=%h idx=%h want 0 0", sorter_data_in, sorter_index_in);
    end
    reset = 1'b1;
    tick();
    total++;
    if (sorter_reset !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got sorter_reset=%b in_ready=%b want 0 1", sorter_reset, in_ready);
    end
  endtask

  task automatic test_basic();
    int f[SIZE];
    f = '{7, 2, 9, 4};
    send_frame(f, SIZE);
    drain_frame(f, 0);
  endtask

  task automatic test_backpressure();
    int f[SIZE];
    for (int i = 0; i < SIZE; i++) f[i] = int'($urandom_range(0, 255));
    send_frame(f, SIZE);
    drain_frame(f, 2);
  endtask

  task automatic test_back_to_back();
    int f1[SIZE];
    int f2[SIZE];
    int p0;
    f1 = '{1, 1, 1, 1};
    f2 = '{3, 0, 3, 0};
    p0 = rst_pulses;
    send_frame(f1, SIZE);
    drain_frame(f1, 0);
    send_frame(f2, SIZE);
    drain_frame(f2, 1);
    total++;
    if (rst_pulses - p0 !== 2) begin
      bad++;
      $display("FAIL reset_pulses: got %0d want 2", rst_pulses - p0);
    end
  endtask

  task automatic test_random();
    int f[SIZE];
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < SIZE; i++)
        f[i] = (n % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
      send_frame(f, SIZE);
      drain_frame(f, 1);
    end
  endtask

  task automatic test_reset_mid();
    int f[SIZE];
    for (int i = 0; i < SIZE; i++) f[i] = int'($urandom_range(0, 255));
    hold_done = 1'b1;
    send_frame(f, SIZE);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    total++;
    if ({in_ready, sorter_reset, sorter_ready, out_valid, busy, timeout_err} !== 6'b010000) begin
      bad++;
      $display("FAIL reset_in_wait: got in_ready=%b srst=%b srdy=%b ov=%b busy=%b to=%b want 0 1 0 0 0 0",
               in_ready, sorter_reset, sorter_ready, out_valid, busy, timeout_err);
    end
    reset = 1'b1;
    hold_done = 1'b0;
    tick();
    send_frame(f, 2);
    reset = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || sorter_reset !== 1'b1 || sorter_data_in !== '0) begin
      bad++;
      $display("FAIL reset_in_fill: got busy=%b in_ready=%b srst=%b data=%h want 0 0 1 0",
               busy, in_ready, sorter_reset, sorter_data_in);
    end
    reset = 1'b1;
    tick();
    for (int i = 0; i < SIZE; i++) f[i] = int'($urandom_range(0, 255));
    send_frame(f, SIZE);
    drain_frame(f, 1);
  endtask

  task automatic test_timeout();
    int f[SIZE];
    for (int i = 0; i < SIZE; i++) f[i] = int'($urandom_range(0, 255));
    hold_done = 1'b1;
    send_frame(f, SIZE);
`ifdef SORT_TIMEOUT_EN
    repeat (TO - 1) tick();
    total++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: got timeout_err=%b busy=%b want 0 1", timeout_err, busy);
    end
    tick();
    total++;
    if (timeout_err !== 1'b1 || sorter_reset !== 1'b1) begin
      bad++;
      $display("FAIL timeout_fire: got timeout_err=%b sorter_reset=%b want 1 1", timeout_err, sorter_reset);
    end
    tick();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || sorter_ready !== 1'b0) begin
      bad++;
      $display("FAIL timeout_return: got in_ready=%b busy=%b sorter_ready=%b want 1 0 0",
               in_ready, busy, sorter_ready);
    end
    hold_done = 1'b0;
    send_frame(f, SIZE);
    drain_frame(f, 0);
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: got %b want 1", timeout_err);
    end
`else
    repeat (3 * TO) tick();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL wait_forever: got busy=%b in_ready=%b ov=%b to=%b want 1 0 0 0",
               busy, in_ready, out_valid, timeout_err);
    end
    hold_done = 1'b0;
    drain_frame(f, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sort_frame_scheduler.md
Name: sort_frame_scheduler

Overview:
- Sequences one instance of the recursive bitonic sorter network, which is instantiated outside this block.
- Collects a frame of SIZE samples from a valid/ready input stream and tags each sample with its arrival index.
- Clears the sorter, launches it, waits for its done flag, captures the sorted lanes, then streams them out one per handshake.
- Sits between the sample front-end and downstream consumers of ranked samples and indices.

Parameters:
- SIZE, 4, lanes per frame; power of two, at least 2; must match the sorter's SIZE.
- TIMEOUT_CYCLES, 256, watchdog limit in WAIT; used only with SORT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low; 0 = reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid && in_ready.
- in_data  in  NETWORK_WIDTH  input sample.
- out_valid  out  1  sorted entry valid.
- out_ready  in  1  downstream accepts the entry.
- out_data  out  NETWORK_WIDTH  sorted sample.
- out_index  out  INDEX_WIDTH  arrival index of that sample.
- out_last  out  1  marks the final entry of a frame.
- sorter_reset  out  1  sorter's synchronous active-high reset.
- sorter_ready  out  1  sorter start.
- sorter_data_in  out  SIZE*NETWORK_WIDTH  frame to sort; lane i = arrival i.
- sorter_index_in  out  SIZE*INDEX_WIDTH  lane i = i.
- sorter_data_out  in  SIZE*NETWORK_WIDTH  sorter result.
- sorter_index_out  in  SIZE*INDEX_WIDTH  sorter result indices.
- sorter_done  in  1  sorter done; sticky until sorter_reset.
- busy  out  1  high in every state except FILL.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset values (while reset==0): state FILL, fill/drain counters 0, all frame and result buffers 0, sorter_reset=1, sorter_ready=0, out_valid=0, out_last=0, busy=0, timeout_err=0. in_ready=0 while reset is asserted.
- Reset mid-operation: the partial or in-flight frame is discarded; the sorter is held in reset throughout.
- All outputs are registered except in_ready, which is decoded from state.
- FILL:
  - in_ready=1; sorter_reset deasserts on the first cycle after reset is released.
  - Each accepted beat writes frame[cnt]=in_data and idx[cnt]=cnt, then increments cnt.
  - Accepting the beat with cnt==SIZE-1 sets cnt=0 and moves to CLEAR.
- CLEAR: in_ready=0; sorter_reset=1 for exactly one cycle; then LAUNCH.
- LAUNCH: sorter_ready=1 for exactly one cycle (the sorter latches it internally); then WAIT.
  - Latency from the last input accept to sorter_ready high is 2 cycles.
- WAIT:
  - sorter_ready=0; sorter_data_in and sorter_index_in stay stable from FILL exit until DRAIN exit.
  - On sorter_done==1: capture sorter_data_out and sorter_index_out into the result buffer, then DRAIN.
  - sorter_done is ignored in every other state.
- DRAIN:
  - out_valid=1; out_data/out_index = result lane ptr, with ptr starting at 0 and ascending.
  - out_last = (ptr==SIZE-1).
  - ptr advances only on out_valid && out_ready. Outputs hold stable under backpressure.
  - The handshake on the last entry clears out_valid and returns to FILL; in_ready rises the next cycle.
- No overlap: input is not accepted during CLEAR, LAUNCH, WAIT or DRAIN.
- Counter widths are $clog2(SIZE); no wrap beyond SIZE-1.

Optional Feature:
- Macro: SORT_TIMEOUT_EN.
- Defined:
  - A wait counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without sorter_done: timeout_err is set sticky (cleared only by reset), the frame is dropped, and the block goes to CLEAR then FILL (not LAUNCH).
- Undefined: no counter is built; timeout_err is tied 0; WAIT waits indefinitely.

Decomposition:
- Package sort_sched_pkg holds:
  - the state enum {FILL, CLEAR, LAUNCH, WAIT, DRAIN};
  - the counter-width function.
- NETWORK_WIDTH and INDEX_WIDTH come from the shared core/network parameter headers; they are not redefined here.
- Single module; no sub-module is warranted.

Test Plan:
- SIZE=4, inputs 7,2,9,4 with out_ready=1 -> sorted data out per sorter direction, indices match arrival (e.g. 2->idx1); out_last on the 4th beat; sorter_ready rises 2 cycles after the 4th accept.
- out_ready held 0 for 5 cycles in DRAIN -> out_data/out_index stable and ptr frozen; resumes at the same entry.
- Back-to-back frames 1,1,1,1 then 3,0,3,0 -> one sorter_reset pulse per frame; no data from frame 1 leaks into frame 2; ties keep valid indices.
- Reset (0) asserted in WAIT and again after 2 FILL beats -> all outputs at reset values; next frame starts at idx 0.
- SORT_TIMEOUT_EN, TIMEOUT_CYCLES=16, sorter_done tied 0 -> timeout_err=1 after 16 WAIT cycles; block returns to FILL with in_ready=1; flag persists.
- Without the macro, same stimulus -> remains in WAIT; timeout_err=0.
